serial_paralelo_rx: RTL

//  Receive-side deserializer that sits directly upstream of the demux stage.

---
 rtl/serial_paralelo_rx_if.sv | 26 ++
 rtl/serial_paralelo_rx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx_if.sv
// Purpose: serial lane in / byte stream out bundle between the lane and the demux.
// Latency: n/a (wires only).
// Backpressure: none; the serial lane cannot be stalled and the demux must accept every VALID pulse.
interface serial_paralelo_rx_if;
    // Signal names follow the deserializer's point of view.
    logic       i_serial_in;  // serial data, MSB of each byte first
    logic [7:0] o_data_out;   // assembled byte towards demux Rx_buffer
    logic       o_valid_out;  // 1-cycle pulse: o_data_out holds a new non-COM byte
    logic       o_active;     // high while byte-locked

    // Lane source / byte consumer side.
    modport master (
        output i_serial_in,
        input  o_data_out,
        input  o_valid_out,
        input  o_active
    );

    // Deserializer side.
    modport slave (
        input  i_serial_in,
        output o_data_out,
        output o_valid_out,
        output o_active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Purpose: 1-bit lane deserializer; locks to byte boundaries on a run of COM characters, then forwards non-COM bytes.
// Latency: a byte whose last bit is sampled at posedge k is on o_data_out/o_valid_out right after posedge k.
// Backpressure: none; the lane is free-running and every forwarded byte is a single-cycle valid pulse.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM_CHAR   = 8'hBC,  // alignment / idle character
    parameter int unsigned LOCK_COUNT = 4       // consecutive aligned COMs needed to lock (2..15)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,  // synchronous, active-high
    serial_paralelo_rx_if.slave       io_rx
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,  // sliding bit-by-bit compare against COM_CHAR
        ST_ALIGN  = 2'd1,  // candidate boundary found, counting aligned COMs
        ST_ACTIVE = 2'd2   // locked; only reset leaves this state
    } state_t;

    localparam logic [3:0] LP_LOCK = 4'(LOCK_COUNT);

    // Registered state
    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_com_cnt;
    logic [7:0] r_data;
    logic       r_valid;

    // Next-state values
    state_t     w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [3:0] w_com_cnt_nxt;
    logic [7:0] w_data_nxt;
    logic       w_valid_nxt;

    // Combinational helpers
    logic [7:0] w_window;
    logic       w_is_com;
    logic       w_byte_end;
    logic [3:0] w_com_inc;

    // The current sample completes an 8-bit window with the seven previous bits.
    assign w_window   = {r_shift[6:0], io_rx.i_serial_in};
    assign w_is_com   = (w_window == COM_CHAR);
    assign w_byte_end = (r_bit_cnt == 3'd7);

    // COM counter increment that never exceeds the lock threshold.
    assign w_com_inc  = (r_com_cnt >= LP_LOCK) ? LP_LOCK : (r_com_cnt + 4'd1);

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        w_com_cnt_nxt = r_com_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;

        case (r_state)
            ST_SEARCH: begin
                // Keep the byte counter parked; it only matters once a boundary is guessed.
                w_bit_cnt_nxt = 3'd0;
                if (w_is_com) begin
                    // This sample was bit 7 of a COM, so the next sample is bit 0 of a new byte.
                    w_state_nxt   = ST_ALIGN;
                    w_com_cnt_nxt = 4'd1;
                end
            end

            ST_ALIGN: begin
                if (w_byte_end) begin
                    if (w_is_com) begin
                        w_com_cnt_nxt = w_com_inc;
                        if (w_com_inc == LP_LOCK) begin
                            w_state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        // Boundary guess was wrong; resume sliding search on the next bit
                        // without rescanning this window.
                        w_state_nxt   = ST_SEARCH;
                        w_com_cnt_nxt = 4'd0;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
            end

            ST_ACTIVE: begin
                // COMs after lock are idles: shown on the data bus but not flagged valid.
                if (w_byte_end) begin
                    w_data_nxt  = w_window;
                    w_valid_nxt = !w_is_com;
                end
            end

            default: begin
                w_state_nxt   = ST_SEARCH;
                w_bit_cnt_nxt = 3'd0;
                w_com_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Shift register, counters and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= 4'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
        end else begin
            r_shift   <= w_window;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    // Drive the demux-facing outputs straight from flops.
    assign io_rx.o_data_out  = r_data;
    assign io_rx.o_valid_out = r_valid;
    assign io_rx.o_active    = (r_state == ST_ACTIVE);

endmodule
